bimodal_predictor: RTL and testbench
====================================

# bimodal_predictor

Multi-slot, PC-indexed bimodal direction predictor. It is the parametrised successor of the single-prediction base table. Each query returns FETCH_WIDTH saturating-counter predictions for consecutive instructions PC, PC+4, …, PC+4·(FETCH_WIDTH-1), with one-cycle read latency. The table is banked FETCH_WIDTH ways so every slot reads in parallel. The block self-initialises after reset, and it forwards a same-cycle update into the read path. It sits in the BPU as the fallback predictor under the tagged components.

## Interface
Parameters:
- FETCH_WIDTH, 4: predictions per query; power of two, ≤ 2^TABLE_DEPTH_EXP2
- TABLE_DEPTH_EXP2, 10: log2 of total counter entries
- CTR_WIDTH, 2: saturating counter width, ≥ 1
- PC_WIDTH, 32: PC width
- CTR_INIT, 1: counter value written by the init sweep (weakly not-taken)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- query_valid_i  in  1  query request this cycle
- query_pc_i  in  PC_WIDTH  PC of fetch slot 0
- pred_valid_o  out  1  predictions below are valid (registered)
- pred_taken_o  out  FETCH_WIDTH  bit k = MSB of slot-k counter
- pred_ctr_o  out  FETCH_WIDTH*CTR_WIDTH  slot-k counter at bits [k*CTR_WIDTH +: CTR_WIDTH]
- update_valid_i  in  1  commit-time training request
- update_pc_i  in  PC_WIDTH  PC of the resolved branch
- update_taken_i  in  1  resolved direction
- update_ctr_i  in  CTR_WIDTH  counter value this block returned for that branch at fetch
- init_done_o  out  1  init sweep finished; block accepts queries and updates

## Operation
- Entry index e = pc[2 +: TABLE_DEPTH_EXP2]. Bank = e mod FETCH_WIDTH, row = e / FETCH_WIDTH.
- Each bank is an independent 1R1W synchronous RAM of 2^TABLE_DEPTH_EXP2/FETCH_WIDTH rows.
- Query: slot k uses entry e_k = (e + k) mod 2^TABLE_DEPTH_EXP2, and each bank serves exactly one slot.
  - Register the rotation r = e mod FETCH_WIDTH with the request.
  - Next cycle, slot k output = bank (r+k) mod FETCH_WIDTH.
  - Index wrap-around at the top of the table is modulo; PC bits above the index are ignored (no tag).
- Update: new = update_ctr_i + 1 if taken, − 1 if not, saturating at 0 and 2^CTR_WIDTH−1. The new value is written to entry e(update_pc_i) in the cycle update_valid_i is high.
- Forwarding: if an update writes entry e_k in the same cycle a query reads it, slot k returns the new value. RAM read-first data is discarded for that slot.
- State machine:
  - INIT: row pointer p starts at 0. Each cycle, write CTR_INIT to row p of every bank and increment p. After the last row is written, go to RUN.
  - RUN: serve queries and updates; terminal until reset.
- In INIT, queries and updates are ignored and dropped.
- Asserting rst_n low from any state, including mid-sweep, returns the block to INIT with p = 0. RAM contents are not reset; the sweep restarts from row 0.

## Timing
- Reset values: pred_valid_o=0, pred_taken_o=0, pred_ctr_o=0, init_done_o=0, state=INIT, p=0.
- The init sweep takes 2^TABLE_DEPTH_EXP2/FETCH_WIDTH cycles from the first rising edge with rst_n high.
- init_done_o is registered and rises the cycle after the last row write.
- Query latency is 1 cycle: a query at edge t with state RUN gives pred_valid_o=1 after edge t+1, for exactly one cycle per query.
- Back-to-back queries are allowed every cycle with no stall; there is no backpressure.
- When pred_valid_o=0, pred_taken_o and pred_ctr_o are driven to 0.
- An update at edge t is visible to a query issued at edge t (via forwarding) or later.
- A single update port gives no write-write conflicts. An update and the init sweep never overlap because updates are dropped in INIT.

## Test plan
- Reset/init (defaults): rst_n rises → init_done_o=1 exactly 256 cycles later. Queries issued during the sweep give pred_valid_o=0. First RUN query at pc=0x0 → pred_ctr_o slots all 1, pred_taken_o=4'b0000.
- Training: update pc=0x1000, taken=1, ctr=1 → next query pc=0x1000 gives slot0 ctr=2, taken bit0=1; slots 1–3 stay 1.
- Saturation: update ctr=3 taken=1 → entry reads 3; update ctr=0 taken=0 → entry reads 0.
- Wrap and rotation: preload entry 1022 to 3 and entry 1 to 2. Query pc=0xFF8 (e=1022) → slot0 ctr=3, slot3 (entry 1) ctr=2, slots 1–2 = 1.
- Forwarding: in the same cycle, query pc=0x2004 and update pc=0x2008 (taken, ctr=1) → slot1 ctr=2 on the next cycle. The following query confirms the stored value is 2.
- Mid-init reset: pulse rst_n low at sweep cycle 100 → outputs return to reset values, and init_done_o rises 256 cycles after release.

Source files
------------

// File: rtl/bimodal_predictor.sv
// rtl/bimodal_predictor.sv - banked, PC-indexed bimodal direction predictor with init sweep and update forwarding
module bimodal_predictor #(
    parameter int FETCH_WIDTH      = 4,
    parameter int TABLE_DEPTH_EXP2 = 10,
    parameter int CTR_WIDTH        = 2,
    parameter int PC_WIDTH         = 32,
    parameter int CTR_INIT         = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             query_valid_i,
    input  logic [PC_WIDTH-1:0]              query_pc_i,
    output logic                             pred_valid_o,
    output logic [FETCH_WIDTH-1:0]           pred_taken_o,
    output logic [FETCH_WIDTH*CTR_WIDTH-1:0] pred_ctr_o,
    input  logic                             update_valid_i,
    input  logic [PC_WIDTH-1:0]              update_pc_i,
    input  logic                             update_taken_i,
    input  logic [CTR_WIDTH-1:0]             update_ctr_i,
    output logic                             init_done_o
);
    localparam int DEPTH = 1 << TABLE_DEPTH_EXP2;
    localparam int ROWS  = DEPTH / FETCH_WIDTH;
    localparam int SH    = $clog2(FETCH_WIDTH);
    localparam int BW    = (SH > 0) ? SH : 1;
    localparam int RW    = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;
    localparam int EW    = TABLE_DEPTH_EXP2;
    localparam logic [EW-1:0] EMASK    = EW'(FETCH_WIDTH - 1);
    localparam logic [BW-1:0] BMASK    = BW'(FETCH_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   p, p_n;

    function automatic logic [CTR_WIDTH-1:0] sat_next(input logic [CTR_WIDTH-1:0] c,
                                                      input logic t);
        if (t)
            return (c == '1) ? c : c + CTR_WIDTH'(1);
        else
            return (c == '0) ? c : c - CTR_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            p     <= '0;
        end else begin
            state <= state_n;
            p     <= p_n;
        end
    end

    always_comb begin
        state_n = state;
        p_n     = p;
        if (state == S_INIT) begin
            p_n = p + RW'(1);
            if (p == LAST_ROW) begin
                state_n = S_RUN;
                p_n     = '0;
            end
        end
    end

    logic                 sweeping, q_fire, u_fire;
    logic [EW-1:0]        q_e, u_e, q_rot, u_bank;
    logic [RW-1:0]        u_row;
    logic [CTR_WIDTH-1:0] u_new;
    logic                 unused;

    assign sweeping = (state == S_INIT);
    assign q_fire   = query_valid_i & ~sweeping;
    assign u_fire   = update_valid_i & ~sweeping;
    assign q_e      = query_pc_i[2 +: EW];
    assign u_e      = update_pc_i[2 +: EW];
    assign q_rot    = q_e & EMASK;
    assign u_bank   = u_e & EMASK;
    assign u_row    = RW'(u_e >> SH);
    assign u_new    = sat_next(update_ctr_i, update_taken_i);
    assign unused   = ^{query_pc_i[PC_WIDTH-1:EW+2], query_pc_i[1:0],
                        update_pc_i[PC_WIDTH-1:EW+2], update_pc_i[1:0]};

    logic [CTR_WIDTH-1:0] bank_ctr [FETCH_WIDTH];
    logic [CTR_WIDTH-1:0] fwd_val_q;
    logic [BW-1:0]        rot_q;

    for (genvar b = 0; b < FETCH_WIDTH; b++) begin : g_bank
        localparam logic [EW-1:0] BIDX = EW'(b);

        logic [CTR_WIDTH-1:0] mem [ROWS];
        logic [CTR_WIDTH-1:0] rd_q;
        logic [EW-1:0]        ent;
        logic [RW-1:0]        rrow, wrow;
        logic [CTR_WIDTH-1:0] wdata;
        logic                 we, hit, fwd_q;

        // Bank b serves the slot whose entry lands in it: slot (b - rot) mod FETCH_WIDTH.
        assign ent   = q_e + ((BIDX - q_rot) & EMASK);
        assign rrow  = RW'(ent >> SH);
        assign we    = sweeping | (u_fire & (u_bank == BIDX));
        assign wrow  = sweeping ? p : u_row;
        assign wdata = sweeping ? CTR_WIDTH'(CTR_INIT) : u_new;
        assign hit   = u_fire & (u_bank == BIDX) & (u_row == rrow);

        always_ff @(posedge clk) begin
            if (we)
                mem[wrow] <= wdata;
            if (q_fire)
                rd_q <= mem[rrow];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                fwd_q <= 1'b0;
            else if (q_fire)
                fwd_q <= hit;
        end

        assign bank_ctr[b] = fwd_q ? fwd_val_q : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_o <= 1'b0;
            init_done_o  <= 1'b0;
            rot_q        <= '0;
            fwd_val_q    <= '0;
        end else begin
            pred_valid_o <= q_fire;
            init_done_o  <= (state_n == S_RUN);
            if (q_fire) begin
                rot_q     <= BW'(q_rot);
                fwd_val_q <= u_new;
            end
        end
    end

    always_comb begin
        pred_ctr_o   = '0;
        pred_taken_o = '0;
        if (pred_valid_o) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                pred_ctr_o[k*CTR_WIDTH +: CTR_WIDTH] = bank_ctr[(rot_q + BW'(k)) & BMASK];
                pred_taken_o[k] = bank_ctr[(rot_q + BW'(k)) & BMASK][CTR_WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_bimodal_predictor.sv
// tb/tb_bimodal_predictor.sv - randomized and directed self-checking bench for bimodal_predictor
module tb_bimodal_predictor;
    localparam int FW    = 4;
    localparam int TDE   = 10;
    localparam int CW    = 2;
    localparam int PCW   = 32;
    localparam int DEPTH = 1 << TDE;
    localparam int ROWS  = DEPTH / FW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            query_valid = 1'b0;
    logic [PCW-1:0]  query_pc = '0;
    logic            pred_valid_o;
    logic [FW-1:0]   pred_taken_o;
    logic [FW*CW-1:0] pred_ctr_o;
    logic            update_valid = 1'b0;
    logic [PCW-1:0]  update_pc = '0;
    logic            update_taken = 1'b0;
    logic [CW-1:0]   update_ctr = '0;
    logic            init_done_o;

    bimodal_predictor #(
        .FETCH_WIDTH(FW), .TABLE_DEPTH_EXP2(TDE), .CTR_WIDTH(CW), .PC_WIDTH(PCW), .CTR_INIT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .query_valid_i(query_valid), .query_pc_i(query_pc),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_ctr_o(pred_ctr_o),
        .update_valid_i(update_valid), .update_pc_i(update_pc),
        .update_taken_i(update_taken), .update_ctr_i(update_ctr),
        .init_done_o(init_done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flat array of counters indexed by entry number.
    int            model [DEPTH];
    int            sweep = 0;
    bit            exp_v = 1'b0;
    logic [FW*CW-1:0] exp_ctr = '0;
    logic [FW-1:0] exp_tk = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep = 0; exp_v = 0; exp_ctr = '0; exp_tk = '0;
        end else if (sweep < ROWS) begin
            sweep++;
            exp_v = 0; exp_ctr = '0; exp_tk = '0;
            if (sweep == ROWS)
                for (int i = 0; i < DEPTH; i++) model[i] = 1;
        end else begin
            if (update_valid) begin
                int e, v;
                e = int'((update_pc >> 2) % DEPTH);
                v = int'(update_ctr);
                if (update_taken) v = (v == 3) ? 3 : v + 1;
                else              v = (v == 0) ? 0 : v - 1;
                model[e] = v;
            end
            exp_v = query_valid; exp_ctr = '0; exp_tk = '0;
            if (query_valid)
                for (int k = 0; k < FW; k++) begin
                    int ek;
                    ek = int'(((query_pc >> 2) + k) % DEPTH);
                    exp_ctr[k*CW +: CW] = CW'(model[ek]);
                    exp_tk[k] = (model[ek] >= 2);
                end
        end
    end

    always @(negedge clk) begin
        check("pred_valid", 32'(pred_valid_o), 32'(exp_v));
        check("pred_ctr", 32'(pred_ctr_o), 32'(exp_ctr));
        check("pred_taken", 32'(pred_taken_o), 32'(exp_tk));
        check("init_done", 32'(init_done_o), 32'(sweep >= ROWS));
    end

    task automatic idle();
        query_valid = 0; update_valid = 0;
    endtask

    task automatic step(input bit qv, input logic [31:0] qpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [1:0] uc);
        query_valid = qv; query_pc = qpc;
        update_valid = uv; update_pc = upc; update_taken = ut; update_ctr = uc;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rand_inputs();
        int idx;
        idx = ($urandom_range(0, 1) == 1) ? 1008 + $urandom_range(0, 15) : $urandom_range(0, 23);
        query_valid  = $urandom_range(0, 1);
        query_pc     = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
        idx = ($urandom_range(0, 1) == 1) ? 1008 + $urandom_range(0, 15) : $urandom_range(0, 23);
        update_valid = $urandom_range(0, 1);
        update_pc    = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
        update_taken = $urandom_range(0, 1);
        update_ctr   = CW'($urandom_range(0, 3));
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done_o && n < 400) begin
            rand_inputs();
            @(posedge clk); #1;
            n++;
            check({name, "_pred_valid_in_init"}, 32'(pred_valid_o), 32'd0);
        end
        idle();
        check({name, "_cycles"}, 32'(n), 32'(ROWS));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_pred_valid", 32'(pred_valid_o), 32'd0);
        check("rst_pred_ctr", 32'(pred_ctr_o), 32'd0);
        check("rst_init_done", 32'(init_done_o), 32'd0);
        rst_n = 1;
        wait_init("init");

        step(1, 32'h0, 0, 0, 0, 0);
        check("q0_ctr", 32'(pred_ctr_o), 32'h55);
        check("q0_taken", 32'(pred_taken_o), 32'h0);

        step(0, 0, 1, 32'h1000, 1, 2'd1);
        step(1, 32'h1000, 0, 0, 0, 0);
        check("train_ctr", 32'(pred_ctr_o), 32'h56);
        check("train_taken", 32'(pred_taken_o), 32'b0001);
        step(0, 0, 1, 32'h1000, 0, 2'd2);

        step(0, 0, 1, 32'hFF8, 1, 2'd2);
        step(0, 0, 1, 32'h4, 1, 2'd1);
        step(1, 32'hFF8, 0, 0, 0, 0);
        check("wrap_ctr", 32'(pred_ctr_o), 32'h97);
        check("wrap_taken", 32'(pred_taken_o), 32'b1001);

        step(0, 0, 1, 32'h3010, 1, 2'd3);
        step(1, 32'h3010, 0, 0, 0, 0);
        check("sat_hi", 32'(pred_ctr_o[1:0]), 32'd3);
        step(0, 0, 1, 32'h3010, 0, 2'd0);
        step(1, 32'h3010, 0, 0, 0, 0);
        check("sat_lo", 32'(pred_ctr_o[1:0]), 32'd0);
        check("sat_lo_taken", 32'(pred_taken_o[0]), 32'd0);

        step(1, 32'h2004, 1, 32'h2008, 1, 2'd1);
        check("fwd_slot1", 32'(pred_ctr_o[3:2]), 32'd2);
        step(1, 32'h2004, 0, 0, 0, 0);
        check("fwd_stored", 32'(pred_ctr_o[3:2]), 32'd2);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            @(posedge clk); #1;
        end
        query_valid = 1; query_pc = 32'h0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("run_rst_pred_valid", 32'(pred_valid_o), 32'd0);
        check("run_rst_init_done", 32'(init_done_o), 32'd0);
        idle();
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            @(posedge clk); #1;
        end
        rst_n = 0;
        idle();
        #1;
        check("mid_rst_pred_ctr", 32'(pred_ctr_o), 32'd0);
        check("mid_rst_init_done", 32'(init_done_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        wait_init("reinit");
        step(1, 32'h0, 0, 0, 0, 0);
        check("reinit_q0_ctr", 32'(pred_ctr_o), 32'h55);
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
